// File: rtl/fabric_extmem_sched.sv
// Round-robin scheduler sharing one external memory channel between load and store ports; 0-cycle request path,
// grant locked under mem_req_ready backpressure, responses routed by tag with no buffering.
module fabric_extmem_sched #(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int LD_COUNT         = 2,
  parameter int ST_COUNT         = 1,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int DEADLOCK_TIMEOUT = 256,
  localparam int N               = LD_COUNT + ST_COUNT,
  localparam int TAG_W           = (N > 1) ? $clog2(N) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [LD_COUNT-1:0]                  ld_addr_valid,
  output logic [LD_COUNT-1:0]                  ld_addr_ready,
  input  logic [LD_COUNT-1:0][ADDR_WIDTH-1:0]  ld_addr,
  input  logic [ST_COUNT-1:0]                  st_addr_valid,
  output logic [ST_COUNT-1:0]                  st_addr_ready,
  input  logic [ST_COUNT-1:0][ADDR_WIDTH-1:0]  st_addr,
  input  logic [ST_COUNT-1:0]                  st_data_valid,
  output logic [ST_COUNT-1:0]                  st_data_ready,
  input  logic [ST_COUNT-1:0][DATA_WIDTH-1:0]  st_data,
  output logic [LD_COUNT-1:0]                  ld_data_valid,
  input  logic [LD_COUNT-1:0]                  ld_data_ready,
  output logic [LD_COUNT-1:0][DATA_WIDTH-1:0]  ld_data,
  output logic                                 ld_done_valid,
  input  logic                                 ld_done_ready,
  output logic                                 st_done_valid,
  input  logic                                 st_done_ready,
  output logic                                 mem_req_valid,
  input  logic                                 mem_req_ready,
  output logic                                 mem_req_is_store,
  output logic [ADDR_WIDTH-1:0]                mem_req_addr,
  output logic [DATA_WIDTH-1:0]                mem_req_wdata,
  output logic [TAG_W-1:0]                     mem_req_tag,
  input  logic                                 mem_resp_valid,
  output logic                                 mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]                mem_resp_data,
  input  logic [TAG_W-1:0]                     mem_resp_tag,
  output logic                                 error_valid,
  output logic [15:0]                          error_code
);

  // Runtime error codes shared with the rest of the fabric (fabric_common.svh values).
  localparam logic [15:0] RT_MEMORY_TAG_OOB        = 16'h0A01;
  localparam logic [15:0] RT_MEMORY_STORE_DEADLOCK = 16'h0A02;

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TMR_W = $clog2(DEADLOCK_TIMEOUT + 1);
  localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUTSTANDING);
  localparam logic [TMR_W-1:0] TMO_V     = TMR_W'(DEADLOCK_TIMEOUT);
  localparam logic [TAG_W-1:0] LD_CNT_V  = TAG_W'(LD_COUNT);

  if (LD_COUNT < 1) begin : g_bad_ld
    $fatal(1, "fabric_extmem_sched: LD_COUNT must be >= 1");
  end
  if (ST_COUNT < 1) begin : g_bad_st
    $fatal(1, "fabric_extmem_sched: ST_COUNT must be >= 1");
  end

  logic [TAG_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  lock_q, lock_d;
  logic [TAG_W-1:0]      lock_idx_q, lock_idx_d;
  logic [ADDR_WIDTH-1:0] lock_addr_q, lock_addr_d;
  logic [DATA_WIDTH-1:0] lock_wdata_q, lock_wdata_d;
  logic                  lock_store_q, lock_store_d;
  logic [OUT_W-1:0]      outst_q [LD_COUNT];
  logic [OUT_W-1:0]      outst_d [LD_COUNT];
  logic [TMR_W-1:0]      tmr_q   [ST_COUNT];
  logic [TMR_W-1:0]      tmr_d   [ST_COUNT];
  logic [15:0]           ld_cred_q, ld_cred_d;
  logic [15:0]           st_cred_q, st_cred_d;
  logic                  ld_done_vld_q, ld_done_vld_d;
  logic                  st_done_vld_q, st_done_vld_d;
  logic                  err_q, err_d;
  logic [15:0]           err_code_q, err_code_d;

  logic [N-1:0]          elig;
  logic                  any_elig;
  logic [TAG_W-1:0]      arb_idx;
  int                    idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_store;
  logic                  req_vld;
  logic                  req_fire;
  logic [TAG_W-1:0]      grant;
  logic                  grant_store;
  logic [LD_COUNT-1:0]   ld_fire;
  logic                  resp_in_range;
  logic                  oob_evt;
  logic                  dl_evt;

  function automatic logic [15:0] cred_next(input logic [15:0] c, input logic inc, input logic dec);
    logic [15:0] r;
    r = c;
    if (inc && !dec && c != 16'hFFFF) r = c + 16'd1;
    else if (dec && !inc && c != 16'd0) r = c - 16'd1;
    return r;
  endfunction

  always_comb begin
    elig = '0;
    for (int p = 0; p < LD_COUNT; p++) begin
      elig[p] = ld_addr_valid[p] && (outst_q[p] < MAX_OUT_V);
    end
    for (int s = 0; s < ST_COUNT; s++) begin
      elig[LD_COUNT+s] = st_addr_valid[s] && st_data_valid[s];
    end
  end

  // First eligible requester at or after rr_ptr, wrapping.
  always_comb begin
    any_elig = 1'b0;
    arb_idx  = '0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!any_elig && elig[idx]) begin
        any_elig = 1'b1;
        arb_idx  = TAG_W'(idx);
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_store = 1'b0;
    for (int p = 0; p < LD_COUNT; p++) begin
      if (arb_idx == TAG_W'(p)) sel_addr = ld_addr[p];
    end
    for (int s = 0; s < ST_COUNT; s++) begin
      if (arb_idx == TAG_W'(LD_COUNT + s)) begin
        sel_addr  = st_addr[s];
        sel_wdata = st_data[s];
        sel_store = 1'b1;
      end
    end
  end

  // A held grant replays its captured payload so mem_req_* cannot move while stalled.
  assign req_vld          = !rst && (lock_q || any_elig);
  assign req_fire         = req_vld && mem_req_ready;
  assign grant            = lock_q ? lock_idx_q : arb_idx;
  assign grant_store      = lock_q ? lock_store_q : sel_store;
  assign mem_req_valid    = req_vld;
  assign mem_req_tag      = req_vld ? grant : '0;
  assign mem_req_is_store = req_vld && grant_store;
  assign mem_req_addr     = req_vld ? (lock_q ? lock_addr_q : sel_addr) : '0;
  assign mem_req_wdata    = req_vld ? (lock_q ? lock_wdata_q : sel_wdata) : '0;

  always_comb begin
    ld_addr_ready = '0;
    st_addr_ready = '0;
    st_data_ready = '0;
    for (int p = 0; p < LD_COUNT; p++) begin
      ld_addr_ready[p] = req_fire && (grant == TAG_W'(p));
    end
    for (int s = 0; s < ST_COUNT; s++) begin
      st_addr_ready[s] = req_fire && (grant == TAG_W'(LD_COUNT + s));
      st_data_ready[s] = req_fire && (grant == TAG_W'(LD_COUNT + s));
    end
  end

  assign resp_in_range = mem_resp_tag < LD_CNT_V;
  assign oob_evt       = !rst && mem_resp_valid && !resp_in_range;

  always_comb begin
    ld_data_valid  = '0;
    ld_data        = '0;
    mem_resp_ready = !rst;
    for (int p = 0; p < LD_COUNT; p++) begin
      if (mem_resp_tag == TAG_W'(p)) begin
        ld_data_valid[p] = !rst && mem_resp_valid;
        ld_data[p]       = rst ? '0 : mem_resp_data;
        mem_resp_ready   = !rst && ld_data_ready[p];
      end
    end
  end

  assign ld_fire = ld_data_valid & ld_data_ready;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_d       = lock_q;
    lock_idx_d   = lock_idx_q;
    lock_addr_d  = lock_addr_q;
    lock_wdata_d = lock_wdata_q;
    lock_store_d = lock_store_q;
    dl_evt       = 1'b0;
    err_d        = err_q;
    err_code_d   = err_code_q;

    if (req_fire) begin
      lock_d   = 1'b0;
      rr_ptr_d = (grant == TAG_W'(N - 1)) ? '0 : grant + TAG_W'(1);
    end else if (req_vld && !lock_q) begin
      lock_d       = 1'b1;
      lock_idx_d   = arb_idx;
      lock_addr_d  = sel_addr;
      lock_wdata_d = sel_wdata;
      lock_store_d = sel_store;
    end

    // Responses for loads forgotten by a reset can arrive with a zero count; never wrap below 0.
    for (int p = 0; p < LD_COUNT; p++) begin
      outst_d[p] = outst_q[p];
      if (ld_addr_ready[p] && !ld_fire[p]) outst_d[p] = outst_q[p] + OUT_W'(1);
      else if (ld_fire[p] && !ld_addr_ready[p] && outst_q[p] != '0) outst_d[p] = outst_q[p] - OUT_W'(1);
    end

    for (int s = 0; s < ST_COUNT; s++) begin
      tmr_d[s] = '0;
      if (st_addr_valid[s] ^ st_data_valid[s]) begin
        tmr_d[s] = (tmr_q[s] == TMO_V) ? tmr_q[s] : tmr_q[s] + TMR_W'(1);
        if (tmr_d[s] == TMO_V) dl_evt = 1'b1;
      end
    end

    ld_cred_d     = cred_next(ld_cred_q, |ld_fire, ld_done_vld_q && ld_done_ready);
    st_cred_d     = cred_next(st_cred_q, req_fire && grant_store, st_done_vld_q && st_done_ready);
    ld_done_vld_d = ld_cred_d != 16'd0;
    st_done_vld_d = st_cred_d != 16'd0;

    if (!err_q && (oob_evt || dl_evt)) begin
      err_d      = 1'b1;
      err_code_d = oob_evt ? RT_MEMORY_TAG_OOB : RT_MEMORY_STORE_DEADLOCK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      lock_q        <= 1'b0;
      lock_idx_q    <= '0;
      lock_addr_q   <= '0;
      lock_wdata_q  <= '0;
      lock_store_q  <= 1'b0;
      ld_cred_q     <= '0;
      st_cred_q     <= '0;
      ld_done_vld_q <= 1'b0;
      st_done_vld_q <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
      for (int p = 0; p < LD_COUNT; p++) outst_q[p] <= '0;
      for (int s = 0; s < ST_COUNT; s++) tmr_q[s] <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      lock_q        <= lock_d;
      lock_idx_q    <= lock_idx_d;
      lock_addr_q   <= lock_addr_d;
      lock_wdata_q  <= lock_wdata_d;
      lock_store_q  <= lock_store_d;
      ld_cred_q     <= ld_cred_d;
      st_cred_q     <= st_cred_d;
      ld_done_vld_q <= ld_done_vld_d;
      st_done_vld_q <= st_done_vld_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      for (int p = 0; p < LD_COUNT; p++) outst_q[p] <= outst_d[p];
      for (int s = 0; s < ST_COUNT; s++) tmr_q[s] <= tmr_d[s];
    end
  end

  assign ld_done_valid = ld_done_vld_q;
  assign st_done_valid = st_done_vld_q;
  assign error_valid   = err_q;
  assign error_code    = err_code_q;

endmodule

// File: tb/tb_fabric_extmem_sched.sv
// Directed bench for fabric_extmem_sched: request/response scoreboards plus point checks of flow control and errors.
module tb_fabric_extmem_sched;

  localparam logic [15:0] RT_MEMORY_TAG_OOB        = 16'h0A01;
  localparam logic [15:0] RT_MEMORY_STORE_DEADLOCK = 16'h0A02;

  typedef struct packed {
    logic [1:0]  tag;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } resp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       ld_addr_valid, ld_addr_ready;
  logic [1:0][31:0] ld_addr;
  logic [0:0]       st_addr_valid, st_addr_ready;
  logic [0:0][31:0] st_addr;
  logic [0:0]       st_data_valid, st_data_ready;
  logic [0:0][31:0] st_data;
  logic [1:0]       ld_data_valid, ld_data_ready;
  logic [1:0][31:0] ld_data;
  logic             ld_done_valid, ld_done_ready;
  logic             st_done_valid, st_done_ready;
  logic             mem_req_valid, mem_req_ready, mem_req_is_store;
  logic [31:0]      mem_req_addr, mem_req_wdata;
  logic [1:0]       mem_req_tag;
  logic             mem_resp_valid, mem_resp_ready;
  logic [31:0]      mem_resp_data;
  logic [1:0]       mem_resp_tag;
  logic             error_valid;
  logic [15:0]      error_code;

  int    vectors = 0;
  int    miscompares = 0;
  req_t  req_q[$];
  resp_t resp_q[$];

  always #5 clk = ~clk;

  fabric_extmem_sched #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LD_COUNT(2), .ST_COUNT(1),
    .MAX_OUTSTANDING(4), .DEADLOCK_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_addr_valid(ld_addr_valid), .ld_addr_ready(ld_addr_ready), .ld_addr(ld_addr),
    .st_addr_valid(st_addr_valid), .st_addr_ready(st_addr_ready), .st_addr(st_addr),
    .st_data_valid(st_data_valid), .st_data_ready(st_data_ready), .st_data(st_data),
    .ld_data_valid(ld_data_valid), .ld_data_ready(ld_data_ready), .ld_data(ld_data),
    .ld_done_valid(ld_done_valid), .ld_done_ready(ld_done_ready),
    .st_done_valid(st_done_valid), .st_done_ready(st_done_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_is_store(mem_req_is_store), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_tag(mem_req_tag),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag),
    .error_valid(error_valid), .error_code(error_code)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic [1:0] tag, input logic st, input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r = '{tag: tag, st: st, addr: addr, wdata: wdata};
    req_q.push_back(r);
  endtask

  task automatic push_resp(input logic port, input logic [31:0] data);
    resp_t r;
    r = '{port: port, data: data};
    resp_q.push_back(r);
  endtask

  // Scores whatever fires in the current cycle, then moves to 1ns after the next rising edge.
  task automatic tick();
    req_t  r;
    resp_t s;
    if (mem_req_valid && mem_req_ready) begin
      if (req_q.size() == 0) chk("req_unexpected", 64'(mem_req_tag), 64'h99);
      else begin
        r = req_q.pop_front();
        chk("req_hdr", 64'({mem_req_tag, mem_req_is_store, mem_req_addr}), 64'({r.tag, r.st, r.addr}));
        chk("req_wdata", 64'(mem_req_wdata), 64'(r.wdata));
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (ld_data_valid[p] && ld_data_ready[p]) begin
        if (resp_q.size() == 0) chk("resp_unexpected", 64'(p), 64'h99);
        else begin
          s = resp_q.pop_front();
          chk("resp_port", 64'(p), 64'(s.port));
          chk("resp_data", 64'(ld_data[p]), 64'(s.data));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ld_addr_valid = 2'b11; ld_addr = '0;
    st_addr_valid = '0; st_addr = '0; st_data_valid = '0; st_data = '0;
    ld_data_ready = '0; ld_done_ready = 1'b0; st_done_ready = 1'b0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_tag = '0;
    #3;
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_ld_rdy", 64'(ld_addr_ready), 64'd0);
    chk("rst_err", 64'({error_valid, error_code}), 64'd0);
    chk("rst_done", 64'({ld_done_valid, st_done_valid}), 64'd0);
    chk("rst_resp_rdy", 64'(mem_resp_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; ld_addr_valid = 2'b00;
    #1;
    chk("idle_req_valid", 64'(mem_req_valid), 64'd0);

    // Fairness: all three ports valid, channel always ready.
    ld_addr[0] = 32'h100; ld_addr[1] = 32'h200; st_addr[0] = 32'h300; st_data[0] = 32'hA5;
    ld_addr_valid = 2'b11; st_addr_valid = 1'b1; st_data_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      case (i % 3)
        0: push_req(2'd0, 1'b0, 32'h100, 32'h0);
        1: push_req(2'd1, 1'b0, 32'h200, 32'h0);
        default: push_req(2'd2, 1'b1, 32'h300, 32'hA5);
      endcase
      chk("t1_ld_rdy", 64'(ld_addr_ready), (i % 3 == 0) ? 64'd1 : (i % 3 == 1) ? 64'd2 : 64'd0);
      chk("t1_st_rdy", 64'({st_addr_ready, st_data_ready}), (i % 3 == 2) ? 64'd3 : 64'd0);
      chk("t1_st_done", 64'(st_done_valid), (i >= 3) ? 64'd1 : 64'd0);
      tick();
    end
    ld_addr_valid = 2'b00; st_addr_valid = 1'b0; st_data_valid = 1'b0; st_done_ready = 1'b1;
    #1; chk("t1_cred2", 64'(st_done_valid), 64'd1);
    tick();
    chk("t1_cred1", 64'(st_done_valid), 64'd1);
    tick();
    chk("t1_cred0", 64'(st_done_valid), 64'd0);
    st_done_ready = 1'b0;

    // Backpressure lock on port 1; port 0 shows up while the lock is held.
    ld_addr[0] = 32'h111; ld_addr[1] = 32'h222; ld_addr_valid = 2'b10; mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) ld_addr_valid = 2'b11;
      #1;
      chk("t2_lock_hdr", 64'({mem_req_valid, mem_req_tag, mem_req_addr}), 64'({1'b1, 2'd1, 32'h222}));
      chk("t2_lock_rdy", 64'(ld_addr_ready), 64'd0);
      tick();
    end
    mem_req_ready = 1'b1;
    #1; push_req(2'd1, 1'b0, 32'h222, 32'h0);
    chk("t2_p1_fire", 64'(ld_addr_ready), 64'd2);
    tick();
    ld_addr_valid = 2'b01;
    #1; push_req(2'd0, 1'b0, 32'h111, 32'h0);
    chk("t2_p0_fire", 64'(ld_addr_ready), 64'd1);
    tick();
    ld_addr_valid = 2'b00;

    // Outstanding limit: port 0 has 3 in flight; the 4th fires, the 5th stalls.
    ld_addr[0] = 32'h140; ld_addr_valid = 2'b01;
    #1; push_req(2'd0, 1'b0, 32'h140, 32'h0);
    chk("t3_4th_fire", 64'(ld_addr_ready), 64'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_stall_vld", 64'(mem_req_valid), 64'd0);
      chk("t3_stall_rdy", 64'(ld_addr_ready), 64'd0);
      tick();
    end
    mem_resp_valid = 1'b1; mem_resp_tag = 2'd0; mem_resp_data = 32'h1234; ld_data_ready = 2'b01;
    #1; push_resp(1'b0, 32'h1234);
    chk("t3_resp_vld", 64'(ld_data_valid), 64'd1);
    chk("t3_still_stall", 64'(ld_addr_ready), 64'd0);
    tick();
    mem_resp_valid = 1'b0; ld_data_ready = 2'b00;
    #1; push_req(2'd0, 1'b0, 32'h140, 32'h0);
    chk("t3_refire", 64'(ld_addr_ready), 64'd1);
    chk("t3_ld_done", 64'(ld_done_valid), 64'd1);
    tick();
    ld_addr_valid = 2'b00; ld_done_ready = 1'b1;
    tick();
    ld_done_ready = 1'b0;
    #1; chk("t3_ld_drained", 64'(ld_done_valid), 64'd0);

    // Response routing to port 1 with consumer backpressure.
    mem_resp_valid = 1'b1; mem_resp_tag = 2'd1; mem_resp_data = 32'hDEADBEEF; ld_data_ready = 2'b00;
    #1;
    chk("t4_resp_rdy0", 64'(mem_resp_ready), 64'd0);
    chk("t4_ld_vld", 64'(ld_data_valid), 64'd2);
    chk("t4_ld_data", 64'(ld_data[1]), 64'hDEADBEEF);
    tick();
    ld_data_ready = 2'b10;
    #1; push_resp(1'b1, 32'hDEADBEEF);
    chk("t4_resp_rdy1", 64'(mem_resp_ready), 64'd1);
    chk("t4_done_before", 64'(ld_done_valid), 64'd0);
    tick();
    mem_resp_valid = 1'b0; ld_data_ready = 2'b00;
    #1; chk("t4_done_after", 64'(ld_done_valid), 64'd1);

    // Tag out of range, then a deadlock that must not replace the code.
    mem_resp_valid = 1'b1; mem_resp_tag = 2'd3; mem_resp_data = 32'h55;
    #1;
    chk("t5_resp_rdy", 64'(mem_resp_ready), 64'd1);
    chk("t5_no_ld_vld", 64'(ld_data_valid), 64'd0);
    chk("t5_err_pre", 64'(error_valid), 64'd0);
    tick();
    mem_resp_valid = 1'b0;
    chk("t5_err", 64'({error_valid, error_code}), 64'({1'b1, RT_MEMORY_TAG_OOB}));
    st_addr_valid = 1'b1; st_data_valid = 1'b0;
    repeat (10) tick();
    chk("t5_err_kept", 64'({error_valid, error_code}), 64'({1'b1, RT_MEMORY_TAG_OOB}));
    st_addr_valid = 1'b0;

    // Store deadlock from a clean reset.
    rst = 1'b1;
    #1; chk("t6_rst_err", 64'({error_valid, error_code}), 64'd0);
    tick();
    rst = 1'b0; st_addr_valid = 1'b1; st_data_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i >= 7) chk("t6_dl_err", 64'(error_valid), (i == 8) ? 64'd1 : 64'd0);
    end
    chk("t6_dl_code", 64'(error_code), 64'(RT_MEMORY_STORE_DEADLOCK));
    st_addr_valid = 1'b0;

    // Reset asserted with live traffic on the inputs.
    ld_addr[0] = 32'h150; ld_addr_valid = 2'b01; mem_req_ready = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_tag = 2'd0; mem_resp_data = 32'h77; ld_data_ready = 2'b01;
    rst = 1'b1;
    #1;
    chk("t6_rst_req", 64'({mem_req_valid, mem_req_tag, mem_req_addr}), 64'd0);
    chk("t6_rst_rdy", 64'({ld_addr_ready, mem_resp_ready}), 64'd0);
    chk("t6_rst_ld", 64'({ld_data_valid, ld_data[0]}), 64'd0);
    chk("t6_rst_flags", 64'({error_valid, error_code, ld_done_valid, st_done_valid}), 64'd0);
    tick();
    mem_resp_valid = 1'b0; ld_data_ready = 2'b00; rst = 1'b0;
    #1; push_req(2'd0, 1'b0, 32'h150, 32'h0);
    chk("t6_post_fire", 64'(ld_addr_ready), 64'd1);
    tick();
    ld_addr_valid = 2'b00;
    mem_resp_valid = 1'b1; mem_resp_tag = 2'd0; mem_resp_data = 32'h88; ld_data_ready = 2'b01;
    #1; push_resp(1'b0, 32'h88);
    tick();
    mem_resp_valid = 1'b0; ld_data_ready = 2'b00;
    chk("t6_post_done", 64'(ld_done_valid), 64'd1);

    chk("req_q_empty", 64'(req_q.size()), 64'd0);
    chk("resp_q_empty", 64'(resp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
